branch_predictor: RTL
=====================

# branch_predictor

Fetch-stage direction/target predictor that produces the per-instruction prediction consumed by the execute-stage branch resolver. It holds a table of 2-bit saturating counters (BHT) and a direct-mapped branch target buffer (BTB). For each fetch PC it gives a same-cycle prediction: taken flag, predicted target and pc+4. It is trained by resolution updates returned from execute.

## Interface
Parameters:
- BHT_BITS, 6 — log2 of BHT entries; BHT index is pc[BHT_BITS+1:2].
- BTB_BITS, 4 — log2 of BTB entries; BTB index is pc[BTB_BITS+1:2], tag is pc[63:BTB_BITS+2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  **asynchronous, active-high** reset.
- f_pc  in  64  PC of the instruction being fetched.
- p_branch  out  1  predicted taken.
- p_pc_branch  out  64  predicted next PC: BTB target if p_branch, else f_pc+4.
- p_pcplus4  out  64  f_pc+4, wraps modulo 2^64.
- p_idx  out  BHT_BITS  BHT index used for this prediction; carried down the pipe and returned as u_idx.
- u_valid  in  1  one resolved branch/jump this cycle.
- u_pc  in  64  PC of the resolved instruction.
- u_taken  in  1  actual outcome.
- u_is_jump  in  1  resolved instruction is an unconditional jump.
- u_target  in  64  actual taken target.
- u_idx  in  BHT_BITS  p_idx that was produced for this instruction.

## Operation
- State:
  - BHT: 2^BHT_BITS × 2-bit counters.
  - BTB: 2^BTB_BITS entries of {valid, tag, is_jump, target[63:0]}.
- Lookup (combinational from f_pc):
  - btb_hit = valid && tag match.
  - p_branch = btb_hit && (is_jump || bht[p_idx][1]).
  - No BTB hit means not taken, regardless of the counter.
- Update (when u_valid=1):
  - Conditional branch (u_is_jump=0): bht[u_idx] increments if u_taken, decrements otherwise. Saturates at 2'b11 and 2'b00.
  - Jump: BHT is not modified.
  - If u_taken=1: the BTB entry at u_pc's index is written with {1, u_pc tag, u_is_jump, u_target}. This overwrites any existing entry (allocate/replace).
  - If u_taken=0: the BTB is not modified.
- u_valid=0: no state changes.
- u_idx is trusted as given; u_pc is used only for BTB index and tag.
- Read/write collision: if f_pc indexes an entry that is being updated in the same cycle, the lookup returns the pre-update value. There is no bypass.
- Reset values:
  - All BHT counters are 2'b01 (weakly not-taken).
  - All BTB valid bits are 0. Tag, target and is_jump are don't-care but are cleared to 0.
  - Global history (when configured) is 0.
  - With all state at reset: p_branch=0, p_pc_branch=f_pc+4, p_pcplus4=f_pc+4.

## Timing
- Prediction latency is 0 cycles: outputs are pure combinational functions of f_pc and current state.
- Training latency is 1 cycle: an update presented in cycle N affects lookups from cycle N+1.
- At most one update per cycle. The resolver guarantees updates arrive in program order.
- Reset asserted mid-operation clears all state immediately and asynchronously. While reset is high, the outputs show reset-state predictions. The first update is accepted on the first rising edge after reset deasserts.
- Fetch stall has no effect: the lookup simply repeats for the held f_pc.

## Configuration
- BRANCH_PRED_GSHARE_EN defined:
  - A BHT_BITS-wide global history register ghr is added.
  - p_idx = f_pc[BHT_BITS+1:2] ^ ghr.
  - On each u_valid with u_is_jump=0: ghr <= {ghr[BHT_BITS-2:0], u_taken}.
  - Jumps do not shift ghr.
  - History is non-speculative: it is updated only at resolution.
- Undefined: bimodal predictor, p_idx = f_pc[BHT_BITS+1:2], and no ghr exists.
- In both configurations the BHT is trained at u_idx, never at a recomputed index.

## Test plan
- Reset, then f_pc=0x8000_0000 → p_branch=0, p_pc_branch=p_pcplus4=0x8000_0004, p_idx=0 (bimodal).
- Update {u_pc=0x8000_0010, u_taken=1, u_is_jump=0, u_target=0x8000_0100, u_idx=4}, then f_pc=0x8000_0010 → counter becomes 2'b10, p_branch=1, p_pc_branch=0x8000_0100.
- Same branch trained taken ×3, then not-taken ×1 → counter goes 01→10→11→11→10, and the prediction stays taken. Two more not-taken updates → 00, predicted not taken, BTB entry still valid.
- Jump {u_pc=0x8000_0040, u_is_jump=1, u_taken=1, u_target=0x8000_2000} → next cycle f_pc=0x8000_0040 predicts taken to 0x8000_2000. bht[16] is unchanged at 01.
- Aliasing: train 0x8000_0010 taken, then look up 0x8000_0050 (same BTB index, different tag) → p_branch=0. In the same cycle as an update to 0x8000_0010, a lookup of 0x8000_0010 returns the old entry.
- Assert reset between an update edge and the next lookup → all predictions revert to not-taken with pc+4. With BRANCH_PRED_GSHARE_EN, ghr=0: after taken updates T,T,N, ghr=3'b110 in the low bits and p_idx = pc index XOR 0b110.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage bimodal/gshare direction predictor with a direct-mapped BTB.
// Latency: prediction is combinational (0 cycles); training lands 1 cycle after u_valid.
// Backpressure: none; one update per cycle is always accepted, fetch stalls just repeat the lookup.
//
// Ports:
//   clk, reset       - rising-edge clock, asynchronous active-high reset
//   f_pc             - fetch PC being looked up
//   p_branch         - predicted taken (requires a BTB hit)
//   p_pc_branch      - predicted next PC (BTB target when taken, else f_pc+4)
//   p_pcplus4        - f_pc+4, modulo 2^64
//   p_idx            - BHT index used; returned later as u_idx
//   u_valid/u_pc/u_taken/u_is_jump/u_target/u_idx - resolution update from execute
//
// Optional feature: define BRANCH_PRED_GSHARE_EN to XOR a non-speculative
// global history register into the BHT lookup index.
module branch_predictor #(
  parameter int BHT_BITS = 6,
  parameter int BTB_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         f_pc,
  output logic                p_branch,
  output logic [63:0]         p_pc_branch,
  output logic [63:0]         p_pcplus4,
  output logic [BHT_BITS-1:0] p_idx,
  input  logic                u_valid,
  input  logic [63:0]         u_pc,
  input  logic                u_taken,
  input  logic                u_is_jump,
  input  logic [63:0]         u_target,
  input  logic [BHT_BITS-1:0] u_idx
);

  localparam int BHT_N = 1 << BHT_BITS;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam int TAG_W = 64 - BTB_BITS - 2;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             is_jump;
    logic [63:0]      tgt;
  } btb_entry_t;

  logic [1:0]  bht_q [BHT_N];
  logic [1:0]  bht_d [BHT_N];
  btb_entry_t  btb_q [BTB_N];
  btb_entry_t  btb_d [BTB_N];

  // Word-offset bits of the PCs never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], u_pc[1:0]};

  // ---------------- lookup ----------------
  logic [BTB_BITS-1:0] f_btb_idx;
  logic [TAG_W-1:0]    f_tag;
  btb_entry_t          f_entry;
  logic                f_hit;

  assign f_btb_idx = f_pc[BTB_BITS+1:2];
  assign f_tag     = f_pc[63:BTB_BITS+2];
  assign f_entry   = btb_q[f_btb_idx];
  assign f_hit     = f_entry.vld && (f_entry.tag == f_tag);

`ifdef BRANCH_PRED_GSHARE_EN
  logic [BHT_BITS-1:0] ghr_q;
  logic [BHT_BITS-1:0] ghr_d;
  assign p_idx = f_pc[BHT_BITS+1:2] ^ ghr_q;
`else
  assign p_idx = f_pc[BHT_BITS+1:2];
`endif

  // A miss in the BTB forces not-taken: without a target there is nowhere to go.
  assign p_pcplus4   = f_pc + 64'd4;
  assign p_branch    = f_hit && (f_entry.is_jump || bht_q[p_idx][1]);
  assign p_pc_branch = p_branch ? f_entry.tgt : p_pcplus4;

  // ---------------- training ----------------
  logic [BTB_BITS-1:0] u_btb_idx;
  assign u_btb_idx = u_pc[BTB_BITS+1:2];

  always_comb begin
    bht_d = bht_q;
    btb_d = btb_q;
`ifdef BRANCH_PRED_GSHARE_EN
    ghr_d = ghr_q;
`endif
    if (u_valid) begin
      // Conditional branches train the counter at the index captured at fetch,
      // so the update hits the same entry the prediction used.
      if (!u_is_jump) begin
        if (u_taken && (bht_q[u_idx] != 2'b11)) begin
          bht_d[u_idx] = bht_q[u_idx] + 2'd1;
        end else if (!u_taken && (bht_q[u_idx] != 2'b00)) begin
          bht_d[u_idx] = bht_q[u_idx] - 2'd1;
        end
`ifdef BRANCH_PRED_GSHARE_EN
        ghr_d = {ghr_q[BHT_BITS-2:0], u_taken};
`endif
      end
      // Taken outcomes always (re)allocate; not-taken leaves the BTB alone.
      if (u_taken) begin
        btb_d[u_btb_idx] = '{vld:     1'b1,
                             tag:     u_pc[63:BTB_BITS+2],
                             is_jump: u_is_jump,
                             tgt:     u_target};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
      for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
`ifdef BRANCH_PRED_GSHARE_EN
      ghr_q <= '0;
`endif
    end else begin
      bht_q <= bht_d;
      btb_q <= btb_d;
`ifdef BRANCH_PRED_GSHARE_EN
      ghr_q <= ghr_d;
`endif
    end
  end

endmodule
